// File: rtl/accel_dcache_sequencer_pkg.sv
// Shared types and constants for the accelerator data-cache sequencer.
//   scalar_t           32-bit machine word / byte address
//   CACHE_LINE_BYTES   size of one data-cache line in bytes
//   accel_seq_state_t  sequencer FSM states
//   line_align()       rounds a byte address down to its cache-line base
package accel_dcache_sequencer_pkg;

    typedef logic [31:0] scalar_t;

    localparam int unsigned CACHE_LINE_BYTES = 64;
    localparam int unsigned LINE_OFFSET_W    = 6;
    localparam int unsigned OUTSTANDING_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        ISSUE,
        WAIT,
        DONE
    } accel_seq_state_t;

    function automatic scalar_t line_align(input scalar_t a);
        return {a[31:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/accel_dcache_sequencer_outstanding_counter.sv
// Up/down counter tracking accepted-but-unanswered memory requests.
//   clk, reset   clock, asynchronous active-high reset
//   inc          one request accepted this cycle (ignored when full)
//   dec          one response returned this cycle (ignored when empty)
//   count        current number of outstanding requests
//   full         count == MAX_OUTSTANDING
//   empty        count == 0
//   underflow    dec seen while empty (response without a matching request)
module accel_outstanding_counter
    import accel_dcache_sequencer_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inc,
    input  logic                     dec,
    output logic [OUTSTANDING_W-1:0] count,
    output logic                     full,
    output logic                     empty,
    output logic                     underflow
);

    logic inc_ok;
    logic dec_ok;

    assign full      = (count == OUTSTANDING_W'(MAX_OUTSTANDING));
    assign empty     = (count == '0);
    assign underflow = dec && empty;
    assign inc_ok    = inc && !full;
    assign dec_ok    = dec && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc_ok && !dec_ok) begin
            count <= count + 1'b1;
        end else if (dec_ok && !inc_ok) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/accel_dcache_sequencer.sv
// Block-transfer sequencer between the accelerator control port,
// thread_select_stage and the data cache. A start freezes thread issue,
// waits for the pipeline to drain, issues depth line-aligned requests,
// waits for all responses, then releases the stall and pulses done.
//   clk, reset        clock, asynchronous active-high reset
//   start             one-cycle start request, sampled only in IDLE
//   base_addr         byte address, rounded down to a cache line
//   depth             number of cache lines to transfer
//   dcache_req        request valid to dcache_tag_stage
//   dcache_req_addr   line-aligned address of the current request
//   dcache_accept     tag stage takes the request this cycle
//   dcache_response   data stage completes one earlier accepted request
//   pipeline_stall    blocks thread issue in thread_select_stage
//   busy              high from start acceptance through the done cycle
//   done              one-cycle completion pulse
//   protocol_error    sticky: response with nothing outstanding
module accel_dcache_sequencer
    import accel_dcache_sequencer_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES    = 5,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned DEPTH_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        base_addr,
    input  logic [DEPTH_W-1:0] depth,
    output logic               dcache_req,
    output logic [31:0]        dcache_req_addr,
    input  logic               dcache_accept,
    input  logic               dcache_response,
    output logic               pipeline_stall,
    output logic               busy,
    output logic               done,
    output logic               protocol_error
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    accel_seq_state_t state;
    scalar_t          addr;
    logic [DEPTH_W-1:0] remaining;
    logic [DRAIN_W-1:0] drain_cnt;

    logic [OUTSTANDING_W-1:0] out_count;
    logic out_full;
    logic out_empty;
    logic out_underflow;
    logic issue_fire;
    logic drained;

    accel_outstanding_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_outstanding (
        .clk       (clk),
        .reset     (reset),
        .inc       (issue_fire),
        .dec       (dcache_response),
        .count     (out_count),
        .full      (out_full),
        .empty     (out_empty),
        .underflow (out_underflow)
    );

    // Request valid is gated on the live count so the outstanding limit
    // is never exceeded, even in the cycle the counter becomes full.
    assign dcache_req      = (state == ISSUE) && !out_full;
    assign dcache_req_addr = addr;
    assign issue_fire      = dcache_req && dcache_accept;

    // All responses are in once the count is zero, or the last one is
    // arriving this cycle; the latter saves a cycle of latency in WAIT.
    assign drained = out_empty ||
                     ((out_count == OUTSTANDING_W'(1)) && dcache_response);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            addr           <= '0;
            remaining      <= '0;
            drain_cnt      <= '0;
            pipeline_stall <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= line_align(base_addr);
                        remaining <= depth;
                        drain_cnt <= '0;
                        busy      <= 1'b1;
                        if (depth == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state          <= DRAIN;
                            pipeline_stall <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= ISSUE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ISSUE: begin
                    if (issue_fire) begin
                        addr      <= addr + scalar_t'(CACHE_LINE_BYTES);
                        remaining <= remaining - 1'b1;
                        if (remaining == DEPTH_W'(1)) begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (drained) begin
                        state          <= DONE;
                        done           <= 1'b1;
                        pipeline_stall <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Setting wins over clearing so a spurious response coinciding with
    // an accepted start is still reported.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            protocol_error <= 1'b0;
        end else if (out_underflow) begin
            protocol_error <= 1'b1;
        end else if ((state == IDLE) && start) begin
            protocol_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_accel_dcache_sequencer.sv
// Directed bench for accel_dcache_sequencer with default parameters
// (DRAIN_CYCLES=5, MAX_OUTSTANDING=4, DEPTH_W=8).
module tb_accel_dcache_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [7:0]  depth;
    logic        dcache_req;
    logic [31:0] dcache_req_addr;
    logic        dcache_accept;
    logic        dcache_response;
    logic        pipeline_stall;
    logic        busy;
    logic        done;
    logic        protocol_error;

    accel_dcache_sequencer #(
        .DRAIN_CYCLES    (5),
        .MAX_OUTSTANDING (4),
        .DEPTH_W         (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .base_addr       (base_addr),
        .depth           (depth),
        .dcache_req      (dcache_req),
        .dcache_req_addr (dcache_req_addr),
        .dcache_accept   (dcache_accept),
        .dcache_response (dcache_response),
        .pipeline_stall  (pipeline_stall),
        .busy            (busy),
        .done            (done),
        .protocol_error  (protocol_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // bench-side transfer bookkeeping
    int          cycle;
    int          n_acc;
    int          n_done;
    int          n_hold;
    int          first_req;
    int          done_cycle;
    int          done_stall;
    int          done_busy;
    int          model_out;
    int          bp_cnt;
    int          resp_mode;   // 0 manual, 1 response 2 cycles after accept, 2 respond while outstanding
    bit          bp_mode;     // accept held low 4 cycles per request
    bit          stall_seen;
    logic [3:0]  rsp_pipe;
    logic [31:0] exp_base;
    logic [31:0] acc_addrs[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observe the current cycle, advance one clock, then drive the next cycle.
    task automatic step();
        logic [31:0] e;
        if (dcache_req) begin
            e = exp_base + (32'(n_acc) << 6);
            check("req_addr", dcache_req_addr, e);
            if (first_req < 0) first_req = cycle;
            if (!dcache_accept) n_hold++;
        end
        if (dcache_response && model_out > 0) model_out--;
        if (dcache_req && dcache_accept) begin
            acc_addrs.push_back(dcache_req_addr);
            n_acc++;
            model_out++;
            rsp_pipe[2] = 1'b1;
            bp_cnt = 0;
        end else if (dcache_req) begin
            bp_cnt++;
        end
        if (done) begin
            n_done++;
            done_cycle = cycle;
            done_stall = 32'(pipeline_stall);
            done_busy  = 32'(busy);
        end
        if (pipeline_stall) stall_seen = 1'b1;
        @(posedge clk);
        #1;
        cycle++;
        rsp_pipe = rsp_pipe >> 1;
        if (resp_mode == 1) dcache_response = rsp_pipe[0];
        if (resp_mode == 2) dcache_response = (model_out > 0);
        if (bp_mode) dcache_accept = dcache_req && (bp_cnt == 4);
    endtask

    task automatic start_xfer(input logic [31:0] b, input logic [7:0] d);
        cycle      = 0;
        n_acc      = 0;
        n_done     = 0;
        n_hold     = 0;
        first_req  = -1;
        done_cycle = -1;
        done_stall = -1;
        done_busy  = -1;
        model_out  = 0;
        bp_cnt     = 0;
        rsp_pipe   = '0;
        stall_seen = 1'b0;
        acc_addrs.delete();
        exp_base   = {b[31:6], 6'b0};
        base_addr  = b;
        depth      = d;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int k;
        k = 0;
        while (n_done == 0 && k < budget) begin
            step();
            k++;
        end
        if (n_done == 0) check("done_timeout", 32'(n_done), 1);
        repeat (3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        base_addr       = '0;
        depth           = '0;
        dcache_accept   = 1'b0;
        dcache_response = 1'b0;
        resp_mode       = 0;
        bp_mode         = 1'b0;
        exp_base        = '0;
        rsp_pipe        = '0;
        model_out       = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   32'(dcache_req), 0);
        check("rst_addr",  dcache_req_addr, 32'h0);
        check("rst_stall", 32'(pipeline_stall), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        check("rst_perr",  32'(protocol_error), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic transfer: responses 2 cycles after each accept
        dcache_accept = 1'b1;
        resp_mode     = 1;
        start_xfer(32'h0000_1004, 8'd3);
        check("basic_stall_c1", 32'(pipeline_stall), 1);
        check("basic_busy_c1",  32'(busy), 1);
        run_until_done(60);
        check("basic_first_req", 32'(first_req), 6);
        check("basic_accepts",   32'(n_acc), 3);
        check("basic_addr0",     acc_addrs[0], 32'h0000_1000);
        check("basic_addr2",     acc_addrs[2], 32'h0000_1080);
        check("basic_done_cnt",  32'(n_done), 1);
        check("basic_done_cyc",  32'(done_cycle), 11);
        check("basic_done_stall", 32'(done_stall), 0);
        check("basic_done_busy", 32'(done_busy), 1);
        check("basic_idle_busy", 32'(busy), 0);
        check("basic_perr",      32'(protocol_error), 0);

        // Backpressure: accept low 4 cycles per request
        bp_mode       = 1'b1;
        dcache_accept = 1'b0;
        start_xfer(32'h0000_2000, 8'd2);
        run_until_done(80);
        check("bp_accepts",  32'(n_acc), 2);
        check("bp_held",     32'(n_hold), 8);
        check("bp_done_cnt", 32'(n_done), 1);
        check("bp_done_cyc", 32'(done_cycle), 18);
        bp_mode       = 1'b0;

        // Outstanding limit, then same-cycle accept+response
        dcache_accept   = 1'b1;
        resp_mode       = 0;
        dcache_response = 1'b0;
        start_xfer(32'h0000_4000, 8'd8);
        repeat (25) step();
        check("lim_accepts", 32'(n_acc), 4);
        check("lim_req_low", 32'(dcache_req), 0);
        dcache_response = 1'b1;
        step();
        dcache_response = 1'b0;
        check("lim_req_resume", 32'(dcache_req), 1);
        dcache_response = 1'b1;          // accept + response together
        step();
        check("same_cyc_req", 32'(dcache_req), 1);
        dcache_response = 1'b0;
        step();
        check("same_cyc_full", 32'(dcache_req), 0);
        resp_mode = 2;
        run_until_done(80);
        check("lim_total_acc", 32'(n_acc), 8);
        check("lim_done_cnt",  32'(n_done), 1);
        check("lim_perr",      32'(protocol_error), 0);
        resp_mode       = 0;
        dcache_response = 1'b0;

        // depth==0: immediate done, no stall, no requests
        start_xfer(32'h0000_0100, 8'd0);
        check("d0_done_c1",  32'(done), 1);
        check("d0_stall_c1", 32'(pipeline_stall), 0);
        repeat (3) step();
        check("d0_done_cnt", 32'(n_done), 1);
        check("d0_stall",    32'(stall_seen), 0);
        check("d0_accepts",  32'(n_acc), 0);

        // Address wrap
        resp_mode = 1;
        start_xfer(32'hFFFF_FFC0, 8'd2);
        run_until_done(60);
        check("wrap_accepts", 32'(n_acc), 2);
        check("wrap_addr0",   acc_addrs[0], 32'hFFFF_FFC0);
        check("wrap_addr1",   acc_addrs[1], 32'h0000_0000);
        check("wrap_perr",    32'(protocol_error), 0);
        resp_mode = 0;

        // Spurious response in IDLE
        dcache_response = 1'b1;
        step();
        dcache_response = 1'b0;
        check("perr_set", 32'(protocol_error), 1);
        step();
        check("perr_sticky", 32'(protocol_error), 1);
        start_xfer(32'h0000_0000, 8'd0);
        check("perr_cleared", 32'(protocol_error), 0);
        repeat (3) step();

        // Async reset mid-ISSUE with 2 outstanding
        dcache_accept = 1'b1;
        start_xfer(32'h0000_0000, 8'd8);
        repeat (7) step();
        check("rstx_accepts", 32'(n_acc), 2);
        #2;
        reset = 1'b1;
        #1;
        check("rstx_req_async",   32'(dcache_req), 0);
        check("rstx_stall_async", 32'(pipeline_stall), 0);
        @(posedge clk);
        #1;
        check("rstx_req",   32'(dcache_req), 0);
        check("rstx_addr",  dcache_req_addr, 32'h0);
        check("rstx_stall", 32'(pipeline_stall), 0);
        check("rstx_busy",  32'(busy), 0);
        check("rstx_done",  32'(done), 0);
        reset  = 1'b0;
        n_done = 0;
        repeat (5) step();
        check("rstx_no_done", 32'(n_done), 0);
        check("rstx_idle_req", 32'(dcache_req), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
